// File: rtl/mmss_stopwatch_ctrl.sv
// Run/pause/lap/clear controller for a 00:00-59:59 stopwatch.
// Drives the BCD counter ticks and clear, and selects the display digits.
module mmss_stopwatch_ctrl #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_run,
  input  logic       key_lap,
  input  logic       key_clr,
  input  logic [3:0] sec_q1,
  input  logic [3:0] sec_q0,
  input  logic [3:0] min_q1,
  input  logic [3:0] min_q0,
  output logic       sec_tick,
  output logic       min_tick,
  output logic       cnt_clr,
  output logic [3:0] disp_m1,
  output logic [3:0] disp_m0,
  output logic [3:0] disp_s1,
  output logic [3:0] disp_s0,
  output logic       disp_blank,
  output logic       running,
  output logic       full
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [PW-1:0] P_TERM = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] B_TERM = BW'(BLINK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_PAUSE = 3'd2;
  localparam logic [2:0] S_LAP   = 3'd3;
  localparam logic [2:0] S_FULL  = 3'd4;

  logic [2:0]    state;
  logic [2:0]    nstate;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_n;
  logic [BW-1:0] blink;
  logic          blank;
  logic [15:0]   lap_q;
  logic [15:0]   lap_n;
  logic [15:0]   fb;
  logic          do_clr;
  logic          do_run;
  logic          do_lap;
  logic          counting;
  logic          term;
  logic          at_max;
  logic          clr_n;

  assign fb       = {min_q1, min_q0, sec_q1, sec_q0};
  assign do_clr   = key_clr;
  assign do_run   = key_run & ~key_clr;
  assign do_lap   = key_lap & ~key_run & ~key_clr;
  assign counting = (state == S_RUN) || (state == S_LAP);
  assign term     = counting && (presc == P_TERM);
  assign at_max   = (fb == 16'h5959);

  assign running    = counting;
  assign full       = (state == S_FULL);
  assign disp_blank = blank;

  always_comb begin
    nstate = state;
    lap_n  = lap_q;
    clr_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (do_run) nstate = S_RUN;
        else if (do_clr) clr_n = 1'b1;
      end
      S_RUN: begin
        if (do_run) begin
          nstate = S_PAUSE;
        end else if (do_lap) begin
          nstate = S_LAP;
          lap_n  = fb;
        end
      end
      S_LAP: begin
        if (do_lap) nstate = S_RUN;
        else if (do_run) nstate = S_PAUSE;
      end
      S_PAUSE: begin
        if (do_run) begin
          nstate = S_RUN;
        end else if (do_clr) begin
          nstate = S_IDLE;
          clr_n  = 1'b1;
        end
      end
      S_FULL: begin
        if (do_clr) begin
          nstate = S_IDLE;
          clr_n  = 1'b1;
        end
      end
      default: nstate = S_IDLE;
    endcase
    // Reaching 59:59 at a tick overrides any key pressed that cycle
    if (term && at_max) nstate = S_FULL;
  end

  always_comb begin
    presc_n = presc;
    if (nstate == S_IDLE || nstate == S_FULL) presc_n = '0;
    else if (term) presc_n = '0;
    else if (counting) presc_n = presc + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      presc    <= '0;
      blink    <= '0;
      blank    <= 1'b0;
      lap_q    <= '0;
      sec_tick <= 1'b0;
      min_tick <= 1'b0;
      cnt_clr  <= 1'b0;
      {disp_m1, disp_m0, disp_s1, disp_s0} <= '0;
    end else begin
      state    <= nstate;
      presc    <= presc_n;
      lap_q    <= lap_n;
      sec_tick <= term & ~at_max;
      min_tick <= term & ~at_max & (fb[7:0] == 8'h59);
      cnt_clr  <= clr_n;
      if (state == S_PAUSE && nstate == S_PAUSE) begin
        if (blink == B_TERM) begin
          blink <= '0;
          blank <= ~blank;
        end else begin
          blink <= blink + 1'b1;
        end
      end else begin
        blink <= '0;
        blank <= 1'b0;
      end
      {disp_m1, disp_m0, disp_s1, disp_s0} <=
        (nstate == S_LAP) ? lap_n : fb;
    end
  end

endmodule

// File: tb/tb_mmss_stopwatch_ctrl.sv
// Randomized scoreboard bench for mmss_stopwatch_ctrl.
// A behavioural model predicts each cycle's outputs; a monitor compares them.
module tb_mmss_stopwatch_ctrl;

  localparam int TD   = 4;
  localparam int BD   = 3;
  localparam int NCYC = 4000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_run = 1'b0;
  logic       key_lap = 1'b0;
  logic       key_clr = 1'b0;
  logic [3:0] sec_q1 = '0;
  logic [3:0] sec_q0 = '0;
  logic [3:0] min_q1 = '0;
  logic [3:0] min_q0 = '0;
  logic       sec_tick;
  logic       min_tick;
  logic       cnt_clr;
  logic [3:0] disp_m1;
  logic [3:0] disp_m0;
  logic [3:0] disp_s1;
  logic [3:0] disp_s0;
  logic       disp_blank;
  logic       running;
  logic       full;

  mmss_stopwatch_ctrl #(.TICK_DIV(TD), .BLINK_DIV(BD)) dut (
    .clk(clk), .reset(reset),
    .key_run(key_run), .key_lap(key_lap), .key_clr(key_clr),
    .sec_q1(sec_q1), .sec_q0(sec_q0),
    .min_q1(min_q1), .min_q0(min_q0),
    .sec_tick(sec_tick), .min_tick(min_tick), .cnt_clr(cnt_clr),
    .disp_m1(disp_m1), .disp_m0(disp_m0),
    .disp_s1(disp_s1), .disp_s0(disp_s0),
    .disp_blank(disp_blank), .running(running), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        mt;
    logic        cc;
    logic [15:0] disp;
    logic        blank;
    logic        run;
    logic        full;
  } exp_t;

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_LAP, M_FULL} mode_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  mode_t       m_st = M_IDLE;
  int          run_cyc = 0;
  int          pause_cyc = 0;
  logic [15:0] snap = '0;
  int          cur_sec = 0;
  int          cur_min = 0;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic model_step(output exp_t e);
    logic        c;
    logic        r;
    logic        l;
    logic [15:0] fb;
    mode_t       nst;
    e = '{st: 0, mt: 0, cc: 0, disp: 16'h0, blank: 0, run: 0, full: 0};
    if (reset) begin
      m_st = M_IDLE;
      run_cyc = 0;
      pause_cyc = 0;
      snap = '0;
      return;
    end
    c  = key_clr;
    r  = key_run && !key_clr;
    l  = key_lap && !key_run && !key_clr;
    fb = {bcd(cur_min), bcd(cur_sec)};
    nst = m_st;
    case (m_st)
      M_IDLE:  if (r) nst = M_RUN; else if (c) e.cc = 1;
      M_RUN:   if (r) nst = M_PAUSE;
               else if (l) begin nst = M_LAP; snap = fb; end
      M_LAP:   if (l) nst = M_RUN; else if (r) nst = M_PAUSE;
      M_PAUSE: if (r) nst = M_RUN;
               else if (c) begin nst = M_IDLE; e.cc = 1; end
      M_FULL:  if (c) begin nst = M_IDLE; e.cc = 1; end
      default: nst = M_IDLE;
    endcase
    if (m_st == M_RUN || m_st == M_LAP) begin
      if (run_cyc % TD == TD - 1) begin
        if (cur_sec == 59 && cur_min == 59) begin
          nst = M_FULL;
        end else begin
          e.st = 1;
          e.mt = (cur_sec == 59);
        end
      end
      run_cyc++;
    end
    if (nst == M_IDLE || nst == M_FULL) run_cyc = 0;
    if (nst == M_PAUSE) pause_cyc = (m_st == M_PAUSE) ? pause_cyc + 1 : 0;
    else pause_cyc = 0;
    e.blank = (nst == M_PAUSE) && ((pause_cyc / BD) % 2 == 1);
    e.disp  = (nst == M_LAP) ? snap : fb;
    e.run   = (nst == M_RUN || nst == M_LAP);
    e.full  = (nst == M_FULL);
    m_st = nst;
  endtask

  initial begin
    exp_t e;
    int   rr;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      reset   = (c < 2) || ($urandom_range(0, 299) == 0);
      key_run = ($urandom_range(0, 5) == 0);
      key_lap = ($urandom_range(0, 5) == 0);
      key_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) begin
        rr = $urandom_range(0, 9);
        if (rr < 2) begin
          cur_min = 59;
          cur_sec = 59;
        end else if (rr < 5) begin
          cur_min = $urandom_range(0, 59);
          cur_sec = 59;
        end else begin
          cur_min = $urandom_range(0, 59);
          cur_sec = $urandom_range(0, 59);
        end
      end
      {min_q1, min_q0} = bcd(cur_min);
      {sec_q1, sec_q0} = bcd(cur_sec);
      model_step(e);
      q.push_back(e);
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0",
               q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sec_tick", 16'(sec_tick), 16'(e.st));
      chk("min_tick", 16'(min_tick), 16'(e.mt));
      chk("cnt_clr", 16'(cnt_clr), 16'(e.cc));
      chk("disp", {disp_m1, disp_m0, disp_s1, disp_s0}, e.disp);
      chk("disp_blank", 16'(disp_blank), 16'(e.blank));
      chk("running", 16'(running), 16'(e.run));
      chk("full", 16'(full), 16'(e.full));
    end
  end

endmodule
